jstepper: RTL
=============

# jstepper

Control-timing generator that sits directly upstream of the register, byte and enabler stages. Each step is divided into four clock phases, and the block produces the per-step enable strobe (`clke`) and set strobe (`clks`). It also produces a one-hot step vector that the control decode ANDs into the `we`/`ws` lines of the registers. The set strobe is always nested strictly inside the enable strobe, so a register only latches bus data while its source is driving.

## Interface
- `N_STEPS`, default 6: steps per instruction; legal range 2..16.
- `clk`, input, 1: system clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high; forces IDLE.
- `run`, input, 1: level request to execute instructions; sampled only at instruction boundaries.
- `restart`, input, 1: end the current instruction early; sampled only in phase 3 of a step.
- `step`, output, `N_STEPS`: one-hot current step; bit 0 = step 1; all-zero in IDLE.
- `phase`, output, 2: current phase 0..3; 0 in IDLE.
- `clke`, output, 1: enable strobe; drives the `we` of enablers after control decode.
- `clks`, output, 1: set strobe; drives the `ws` of memory cells after control decode.
- `done`, output, 1: high for one cycle during the final phase of an instruction.

Clocking and reset are fixed: one clock, synchronous active-high reset.

## Operation
- Two-state FSM: IDLE and RUN. The state register holds the FSM state, a 2-bit phase counter and the one-hot step register.
- All outputs are Moore decodes of flop state only, so no input reaches an output combinationally.
- Phase decode in RUN:
  - phase 0: `clke`=1, `clks`=0
  - phase 1: `clke`=1, `clks`=1
  - phase 2: `clke`=1, `clks`=0
  - phase 3: `clke`=0, `clks`=0
- IDLE:
  - `step`=0, `phase`=0, `clke`=0, `clks`=0, `done`=0.
  - If `run`=1, go to RUN with `step`=1 (bit 0) and phase 0. Otherwise stay in IDLE.
- RUN, phases 0–2: phase increments by 1; `step` holds.
- RUN, phase 3, "last step" case:
  - Last step means `step[N_STEPS-1]`=1, or `restart`=1.
  - `done`=1 in this cycle (combinational decode of state plus `restart`, registered-equivalent timing).
  - Next: if `run`=1, go to step 1 / phase 0; else go to IDLE.
- RUN, phase 3, otherwise: `step` shifts left by one and phase goes to 0.
- `run` going low mid-instruction has no effect; the instruction always completes.
- `restart` in phases 0–2 is ignored. `restart` in the last step is redundant and yields identical behaviour.
- `step` is never zero and never multi-hot while in RUN. On any illegal encoding, go to IDLE next cycle.
- `done` exception: `done` is the one output that depends on an input (`restart`). It must be generated from `phase`==3 and the registered step, with `restart` ANDed in, and it is documented as such.

## Timing
- Reset: asserting `reset` on any edge, including mid-step during `clks`, gives IDLE with all outputs 0 on the next cycle. Reset has priority over `run` and `restart`.
- Latency: `run` sampled high in IDLE at edge k gives step 1 / phase 0 (`clke`=1) visible after edge k.
- Instruction length: 4·`N_STEPS` cycles. With `restart` asserted in phase 3 of step m, the length is 4·m cycles.
- Back-to-back instructions: with `run` held high, there are no idle cycles. Step 1 / phase 0 directly follows the final phase 3.
- `clks` is high for exactly 1 cycle per step. `clke` is high for exactly 3 consecutive cycles per step.
- `clks` never rises without `clke` already high, and never stays high after `clke` falls.
- Wrap-around: the step register never shifts past bit `N_STEPS-1`.

## Test plan
- Reset then idle: hold `reset` for 2 cycles, then `run`=0 for 10 cycles → `step`=0, `clke`=`clks`=`done`=0 throughout.
- Single instruction, `N_STEPS`=6: pulse `run` for 1 cycle → 24 cycles of RUN; `step` walks 0x01 through 0x20; `clke` pattern 1,1,1,0 per step; `clks` high only in phase 1; `done` high on cycle 24 only; then IDLE.
- Continuous run: hold `run`=1 for 100 cycles → `done` at cycles 24, 48, 72, 96; no gap cycles between instructions.
- Restart: `run`=1 and `restart`=1 during phase 3 of step 3 → `done` that cycle, next cycle `step`=0x01 / phase 0, instruction length 12. `restart` during phase 1 → ignored.
- Reset mid-operation: assert `reset` during step 4 phase 1 (`clks`=1) → next cycle all outputs 0 in IDLE; with `run` still high, step 1 resumes the following cycle.
- Strobe-nesting checker across all runs: `clks` implies `clke`; `step` is one-hot whenever in RUN.

Source files
------------

// File: rtl/jstepper.sv
// Four-phase control-timing generator: per-step enable/set strobes, a one-hot
// step vector and an end-of-instruction pulse for the register/enabler stages.
module jstepper #(
  parameter int N_STEPS = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               restart,
  output logic [N_STEPS-1:0] step,
  output logic [1:0]         phase,
  output logic               clke,
  output logic               clks,
  output logic               done,
  output logic               dbg_state
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [N_STEPS-1:0] STEP_FIRST = {{(N_STEPS-1){1'b0}}, 1'b1};
  localparam logic [1:0]         PH_LAST    = 2'd3;

  state_t             state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic [N_STEPS-1:0] step_q, step_d;
  logic               clke_q, clks_q;
  logic               step_ok;
  logic               last_step;

  assign step_ok   = $onehot(step_q);
  // An early restart only counts in phase 3; otherwise the last step is the top bit.
  assign last_step = step_q[N_STEPS-1] | restart;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        phase_d = 2'd0;
        step_d  = '0;
        if (run) begin
          state_d = RUN;
          step_d  = STEP_FIRST;
        end
      end
      RUN: begin
        if (!step_ok) begin
          state_d = IDLE;
          phase_d = 2'd0;
          step_d  = '0;
        end else if (phase_q != PH_LAST) begin
          phase_d = phase_q + 2'd1;
        end else if (last_step) begin
          phase_d = 2'd0;
          if (run) begin
            step_d = STEP_FIRST;
          end else begin
            state_d = IDLE;
            step_d  = '0;
          end
        end else begin
          phase_d = 2'd0;
          step_d  = {step_q[N_STEPS-2:0], 1'b0};
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = 2'd0;
        step_d  = '0;
      end
    endcase
  end

  // Strobes are registered from the next-state so they come straight off flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= 2'd0;
      step_q  <= '0;
      clke_q  <= 1'b0;
      clks_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      clke_q  <= (state_d == RUN) && (phase_d != PH_LAST);
      clks_q  <= (state_d == RUN) && (phase_d == 2'd1);
    end
  end

  // done is a one-cycle valid pulse with no ready: the consumer must take it in
  // the cycle it is high. It is the only output with an input term (restart).
  assign done      = (state_q == RUN) && step_ok && (phase_q == PH_LAST) && last_step;
  assign step      = step_q;
  assign phase     = phase_q;
  assign clke      = clke_q;
  assign clks      = clks_q;
  assign dbg_state = (state_q == RUN);

endmodule
